dmem_arb: RTL
=============

DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 Parameter: MAXWAIT, default 3, max cycles a pending host request may be denied while the core holds the port (legal range 1..7).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 creq  input  1  core requests the data-memory port this cycle (load or store).
REQ-005 cwe  input  1  core write enable, qualified by creq.
REQ-006 caddr  input  8  core word address.
REQ-007 cwd  input  16  core write data.
REQ-008 crd  output  16  core read data, combinational passthrough of mrd.
REQ-009 cstall  output  1  core access not performed this cycle; core holds request and operands.
REQ-010 hreq  input  1  host request, level, held until hack.
REQ-011 hwe  input  1  host write enable, stable while hreq high.
REQ-012 haddr  input  8  host word address, stable while hreq high.
REQ-013 hwd  input  16  host write data, stable while hreq high.
REQ-014 hack  output  1  registered one-cycle completion pulse for the host access.
REQ-015 hrd  output  16  registered host read data, valid while hack is high, held afterwards.
REQ-016 hgnt  output  1  combinational: host owns the memory port this cycle.
REQ-017 maddr  output  8  memory address.
REQ-018 mwd  output  16  memory write data.
REQ-019 mwe  output  1  memory write enable, sampled by the memory on the rising edge.
REQ-020 mrd  input  16  memory combinational read data for maddr.

Function
REQ-021 Host FSM states: H_IDLE, H_WAIT, H_ACK; wait counter wcnt, 3 bits.
REQ-022 H_IDLE: hreq=1, creq=0 -> hgnt=1 this cycle, next H_ACK; hreq=1, creq=1 -> core served, next H_WAIT, wcnt<=1; hreq=0 -> stay.
REQ-023 H_WAIT: hreq=1 and (creq=0 or wcnt==MAXWAIT) -> hgnt=1, next H_ACK, wcnt<=0; hreq=1, creq=1, wcnt<MAXWAIT -> core served, wcnt<=wcnt+1; hreq=0 -> next H_IDLE, wcnt<=0, no access, no hack.
REQ-024 H_ACK: hack=1; hreq ignored (no new grant); core served if creq; next H_IDLE.
REQ-025 hgnt=1 -> maddr=haddr, mwd=hwd, mwe=hwe, cstall=creq.
REQ-026 hgnt=0 -> maddr=caddr, mwd=cwd, mwe=creq&cwe, cstall=0.
REQ-027 On the hgnt edge, hrd<=mrd (read performed in grant cycle); on host writes hrd<=mrd (pre-write contents).
REQ-028 Host latency: grant cycle G, hack at cycle G+1; hack never asserted for two consecutive cycles.
REQ-029 Core with creq=1 is stalled at most one cycle per host access; host waits at most MAXWAIT denied cycles.
REQ-030 wcnt never exceeds MAXWAIT; no wrap.
REQ-031 Simultaneous hreq rising with an H_ACK cycle: request not evaluated until H_IDLE in the next cycle.

Reset
REQ-032 rst=1 asynchronously -> state H_IDLE, wcnt=0, hack=0, hrd=16'h0000; combinational outputs follow REQ-026 with the H_IDLE/hreq rule.
REQ-033 Reset during H_WAIT or H_ACK aborts the transaction: no hack emitted afterwards; host re-presents hreq.
REQ-034 mwe=0 while rst=1.

Verification
REQ-035 Core only: creq=1, cwe=1, caddr=8'h10, cwd=16'hBEEF, then read 8'h10 -> crd=16'hBEEF, cstall=0 throughout.
REQ-036 Host only: hreq=1, hwe=0, haddr=8'h10 with memory[8'h10]=16'hBEEF -> hgnt=1 in cycle 0, hack=1 and hrd=16'hBEEF in cycle 1, hack=0 in cycle 2.
REQ-037 Contention, MAXWAIT=3: creq held high every cycle, hreq rises -> core served 3 cycles (cstall=0), hgnt=1 and cstall=1 in 4th cycle, hack in 5th.
REQ-038 Core gap: hreq and creq both high in cycle 0, creq=0 in cycle 1 -> hgnt in cycle 1, hack in cycle 2, wcnt back to 0.
REQ-039 Host write hwe=1, haddr=8'h20, hwd=16'h1234 -> mwe=1 only in grant cycle; core read of 8'h20 afterwards returns 16'h1234.
REQ-040 Async rst pulse between edges while in H_WAIT -> hack stays 0, hrd=0, next hreq handled from H_IDLE.

Source files
------------

// File: rtl/dmem_arb.sv
// Data-memory port arbiter: the core owns the single-port memory by default, and a host
// request is granted when the core is idle or after the host has waited MAXWAIT cycles.
module dmem_arb #(
  parameter int MAXWAIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        creq,
  input  logic        cwe,
  input  logic [7:0]  caddr,
  input  logic [15:0] cwd,
  output logic [15:0] crd,
  output logic        cstall,
  input  logic        hreq,
  input  logic        hwe,
  input  logic [7:0]  haddr,
  input  logic [15:0] hwd,
  output logic        hack,
  output logic [15:0] hrd,
  output logic        hgnt,
  output logic [7:0]  maddr,
  output logic [15:0] mwd,
  output logic        mwe,
  input  logic [15:0] mrd
);

  typedef enum logic [1:0] {
    H_IDLE = 2'd0,
    H_WAIT = 2'd1,
    H_ACK  = 2'd2
  } hstate_t;

  localparam logic [2:0] MAXW = 3'(MAXWAIT);

  hstate_t     state_r;
  hstate_t     state_s;
  logic [2:0]  wcnt_r;
  logic [2:0]  wcnt_s;
  logic        hgnt_s;
  logic        hack_r;
  logic [15:0] hrd_r;

  // Host FSM next state, wait counter and grant decision
  always_comb begin
    state_s = state_r;
    wcnt_s  = wcnt_r;
    hgnt_s  = 1'b0;
    case (state_r)
      H_IDLE: begin
        if (hreq) begin
          if (!creq) begin
            hgnt_s  = 1'b1;
            state_s = H_ACK;
          end else begin
            state_s = H_WAIT;
            wcnt_s  = 3'd1;
          end
        end else begin
          state_s = H_IDLE;
        end
      end
      H_WAIT: begin
        // >= keeps the counter saturated even if it were ever corrupted past MAXW
        if (hreq) begin
          if (!creq || (wcnt_r >= MAXW)) begin
            hgnt_s  = 1'b1;
            state_s = H_ACK;
            wcnt_s  = 3'd0;
          end else begin
            wcnt_s  = wcnt_r + 3'd1;
          end
        end else begin
          state_s = H_IDLE;
          wcnt_s  = 3'd0;
        end
      end
      H_ACK: begin
        state_s = H_IDLE;
        wcnt_s  = 3'd0;
      end
      default: begin
        state_s = H_IDLE;
        wcnt_s  = 3'd0;
      end
    endcase
  end

  // State, wait counter and registered host completion/read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= H_IDLE;
      wcnt_r  <= 3'd0;
      hack_r  <= 1'b0;
      hrd_r   <= 16'h0000;
    end else begin
      state_r <= state_s;
      wcnt_r  <= wcnt_s;
      hack_r  <= hgnt_s;
      if (hgnt_s) begin
        hrd_r <= mrd;
      end else begin
        hrd_r <= hrd_r;
      end
    end
  end

  assign hgnt   = hgnt_s;
  assign hack   = hack_r;
  assign hrd    = hrd_r;
  assign crd    = mrd;
  assign cstall = hgnt_s & creq;
  assign maddr  = hgnt_s ? haddr : caddr;
  assign mwd    = hgnt_s ? hwd : cwd;
  assign mwe    = ~rst & (hgnt_s ? hwe : (creq & cwe));

endmodule
